// File: rtl/adc_sample_ctrl_if.sv
// Sample stream between the ADC sequencer and its consumer.
// s_data carries a signed (two's complement) 12-bit sample.
interface adc_sample_ctrl_if;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/adc_sample_ctrl.sv
// ADC acquisition sequencer: generates the ADC conversion clock, throws away
// the warm-up samples, converts offset-binary to signed and buffers the
// result in a small FIFO towards the stream interface.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE   0  | waiting for en; ad_clk parked low, divider held at zero
// WARMUP 1  | ad_clk running, the first WARMUP strobes are discarded
// RUN    2  | every strobe pushes a converted sample into the FIFO
// DRAIN  3  | ad_clk stopped, no pushes, leave once the FIFO has emptied
module adc_sample_ctrl #(
  parameter int DIV    = 4,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [11:0]       ad_in,
  output logic              ad_clk,
  output logic              busy,
  output logic [7:0]        ovf_cnt,
  output logic [1:0]        state,
  adc_sample_ctrl_if.master s_if
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int WW = $clog2(WARMUP + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DCNT_HALF = DW'(DIV / 2);
  localparam logic [WW-1:0] WCNT_LAST = WW'(WARMUP - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              ad_clk_q, ad_clk_d;
  logic              busy_q, busy_d;
  logic [7:0]        ovf_q, ovf_d;
  logic [11:0]       mem_q [DEPTH];
  logic [11:0]       mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              active_q;
  logic              active_d;
  logic              strobe;
  logic              pop;
  logic              full;
  logic              push;
  logic              wr_en;
  logic [11:0]       sample;

  // The divider only runs while the ADC is being clocked.
  assign active_q = (state_q == ST_WARMUP) || (state_q == ST_RUN);
  assign strobe   = active_q && (dcnt_q == DCNT_LAST);
  assign full     = (cnt_q == FIFO_FULL);
  assign pop      = (cnt_q != '0) && s_if.s_ready;
  // Offset binary to two's complement: flip the MSB.
  assign sample   = {~ad_in[11], ad_in[10:0]};

  // Next-state logic for the sequencer, divider, overflow counter and FIFO.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    dcnt_d   = '0;
    ad_clk_d = 1'b0;
    busy_d   = 1'b0;
    active_d = 1'b0;
    push     = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_WARMUP;
          wcnt_d  = '0;
          ovf_d   = '0;
        end
      end
      ST_WARMUP: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (strobe) begin
          // The strobe that completes warm-up is still thrown away.
          wcnt_d = wcnt_q + WW'(1);
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        push = strobe;
        if (!en) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Divider restarts from zero whenever the ADC clock is (re)started.
    active_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);
    if (active_q && active_d) begin
      dcnt_d = strobe ? '0 : dcnt_q + DW'(1);
    end
    ad_clk_d = active_d && (dcnt_d < DCNT_HALF);
    busy_d   = (state_d != ST_IDLE);

    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    wr_en = push && (!full || pop);
    if (push && full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end

    if (wr_en) begin
      mem_d[wr_q] = sample;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end

    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // All state registers; reset discards any buffered samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dcnt_q   <= '0;
      wcnt_q   <= '0;
      ad_clk_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      ad_clk_q <= ad_clk_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ad_clk      = ad_clk_q;
  assign busy        = busy_q;
  assign ovf_cnt     = ovf_q;
  assign state       = state_q;
  assign s_if.s_valid = (cnt_q != '0);
  // Head entry is masked while empty so the port reads zero after reset.
  assign s_if.s_data  = (cnt_q != '0) ? mem_q[rd_q] : 12'h000;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl: a cycle model predicts state, ad_clk and the
// expected sample queue; DUT output is compared at every falling edge.
module tb_adc_sample_ctrl;

  localparam int DIV    = 4;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] ad_in;
  logic        ad_clk;
  logic        busy;
  logic [7:0]  ovf_cnt;
  logic [1:0]  state;

  adc_sample_ctrl_if s_if ();

  adc_sample_ctrl #(
    .DIV   (DIV),
    .WARMUP(WARMUP),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .ad_in  (ad_in),
    .ad_clk (ad_clk),
    .busy   (busy),
    .ovf_cnt(ovf_cnt),
    .state  (state),
    .s_if   (s_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  int          m_st = 0;
  int          m_dc = 0;
  int          m_wc = 0;
  int          m_ovf = 0;
  int          strobe_cnt = 0;
  int          pop_cnt = 0;
  logic [11:0] exp_q [$];
  logic [11:0] got_log [$];
  bit          m_strobe, m_pop, m_full, m_empty, m_act_old, m_act_new;
  bit          ramp_on = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_dc = 0; m_wc = 0; m_ovf = 0;
      exp_q.delete();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_valid", 32'(s_if.s_valid), 32'd0);
      chk("rst_data", 32'(s_if.s_data), 32'd0);
      chk("rst_adclk", 32'(ad_clk), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    end else begin
      chk("state", 32'(state), 32'(m_st));
      chk("ad_clk", 32'(ad_clk), 32'(((m_st == 1) || (m_st == 2)) && (m_dc < DIV / 2)));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      chk("s_valid", 32'(s_if.s_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("s_data", 32'(s_if.s_data), 32'(exp_q[0]));

      // Predict the coming rising edge from the current inputs.
      m_act_old = (m_st == 1) || (m_st == 2);
      m_strobe  = m_act_old && (m_dc == DIV - 1);
      m_empty   = (exp_q.size() == 0);
      m_full    = (exp_q.size() == DEPTH);
      m_pop     = !m_empty && s_if.s_ready;
      if (m_strobe) strobe_cnt++;
      if (m_pop) begin
        void'(exp_q.pop_front());
        got_log.push_back(s_if.s_data);
        pop_cnt++;
      end
      if ((m_st == 2) && m_strobe) begin
        if (m_full && !m_pop) begin
          if (m_ovf < 255) m_ovf++;
        end else begin
          exp_q.push_back({~ad_in[11], ad_in[10:0]});
        end
      end
      case (m_st)
        0: if (en) begin m_st = 1; m_wc = 0; m_ovf = 0; end
        1: if (!en) m_st = 0;
           else if (m_strobe) begin
             m_wc++;
             if (m_wc == WARMUP) m_st = 2;
           end
        2: if (!en) m_st = 3;
        default: if (m_empty) m_st = 0;
      endcase
      m_act_new = (m_st == 1) || (m_st == 2);
      m_dc = (m_act_old && m_act_new) ? ((m_dc == DIV - 1) ? 0 : m_dc + 1) : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (ramp_on) ad_in = ad_in + 12'd1;
  endtask

  // Stop just before an edge that the model says will be a strobe in RUN.
  task automatic wait_strobe();
    int n = 0;
    while (!((m_st == 2) && (m_dc == DIV - 1)) && (n < 4 * DIV)) begin
      tick();
      n++;
    end
    chk("align_run", 32'(state), 32'd2);
  endtask

  task automatic wait_strobes(input int cnt);
    int base = strobe_cnt;
    int n = 0;
    while ((strobe_cnt < base + cnt) && (n < cnt * DIV + 20)) begin
      tick();
      n++;
    end
    chk("strobe_wait", 32'(strobe_cnt - base), 32'(cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pop_base;
    rst_n = 1'b0;
    en = 1'b0;
    ad_in = 12'h000;
    s_if.s_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tick();

    // Start-up: ramp so that the ninth strobe samples 0x805.
    s_if.s_ready = 1'b1;
    ad_in = 12'h7E1;
    ramp_on = 1'b1;
    en = 1'b1;
    n = 0;
    while (!s_if.s_valid && (n < 100)) begin
      tick();
      n++;
    end
    chk("first_latency", 32'(n), 32'd37);
    chk("first_valid", 32'(s_if.s_valid), 32'd1);
    chk("first_data", 32'(s_if.s_data), 32'h005);

    // Conversion of the extreme codes.
    ramp_on = 1'b0;
    wait_strobe();
    got_log.delete();
    ad_in = 12'h000; tick(); wait_strobe();
    ad_in = 12'h800; tick(); wait_strobe();
    ad_in = 12'hFFF; tick();
    repeat (3) tick();
    chk("conv_count", 32'(got_log.size()), 32'd3);
    if (got_log.size() == 3) begin
      chk("conv_000", 32'(got_log[0]), 32'h800);
      chk("conv_800", 32'(got_log[1]), 32'h000);
      chk("conv_fff", 32'(got_log[2]), 32'h7FF);
    end

    // Overflow: ten blocked strobes into an empty FIFO.
    ramp_on = 1'b1;
    n = 0;
    while (s_if.s_valid && (n < 20)) begin tick(); n++; end
    chk("ovf_pre_empty", 32'(s_if.s_valid), 32'd0);
    s_if.s_ready = 1'b0;
    wait_strobes(10);
    chk("ovf_six", 32'(ovf_cnt), 32'd6);
    chk("ovf_held", 32'(s_if.s_valid), 32'd1);

    // Full FIFO with a pop exactly on the strobe edge.
    wait_strobe();
    s_if.s_ready = 1'b1;
    tick();
    s_if.s_ready = 1'b0;
    chk("full_bnd_ovf", 32'(ovf_cnt), 32'd6);
    chk("full_bnd_valid", 32'(s_if.s_valid), 32'd1);

    // Saturation.
    wait_strobes(300);
    chk("ovf_sat", 32'(ovf_cnt), 32'd255);
    s_if.s_ready = 1'b1;
    n = 0;
    while (s_if.s_valid && (n < 20)) begin tick(); n++; end
    chk("sat_drained", 32'(s_if.s_valid), 32'd0);

    // Stop with three queued entries; en toggles while draining.
    s_if.s_ready = 1'b0;
    wait_strobes(3);
    en = 1'b0;
    s_if.s_ready = 1'b1;
    pop_base = pop_cnt;
    tick();
    chk("drain_state", 32'(state), 32'd3);
    chk("drain_adclk", 32'(ad_clk), 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    n = 0;
    while ((state != 2'd0) && (n < 20)) begin tick(); n++; end
    chk("drain_idle", 32'(state), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_pops", 32'(pop_cnt - pop_base), 32'd3);
    repeat (3) tick();
    chk("idle_stays", 32'(state), 32'd0);

    // Reset in RUN with two queued entries.
    en = 1'b1;
    n = 0;
    while ((state != 2'd2) && (n < 100)) begin tick(); n++; end
    chk("rr_run", 32'(state), 32'd2);
    s_if.s_ready = 1'b0;
    wait_strobes(2);
    chk("rr_queued", 32'(s_if.s_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_valid", 32'(s_if.s_valid), 32'd0);
    chk("rr_state", 32'(state), 32'd0);
    chk("rr_adclk", 32'(ad_clk), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    s_if.s_ready = 1'b1;
    repeat (3) tick();
    chk("rr_wait_idle", 32'(state), 32'd0);
    en = 1'b1;
    n = 0;
    while (!s_if.s_valid && (n < 100)) begin tick(); n++; end
    chk("rr_restart_latency", 32'(n), 32'd37);
    repeat (10) tick();
    en = 1'b0;
    n = 0;
    while ((state != 2'd0) && (n < 20)) begin tick(); n++; end
    chk("end_idle", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving ad_clk period in clk cycles (even, >=2).
REQ-002 The block SHALL have parameter WARMUP, default 8, giving the number of samples discarded after start (>=1).
REQ-003 The block SHALL have parameter DEPTH, default 4, giving output FIFO depth in entries (power of 2).
REQ-004 clk  input  1  the only clock; all logic rises on it.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  level request to run acquisition.
REQ-007 ad_in  input  12  ADC sample, straight binary.
REQ-008 ad_clk  output  1  ADC conversion clock, registered.
REQ-009 s_valid  output  1  output FIFO non-empty.
REQ-010 s_data  output  12  signed head-of-FIFO sample.
REQ-011 s_ready  input  1  downstream accepts s_data when s_valid is high.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 ovf_cnt  output  8  saturating count of dropped samples.
REQ-014 state  output  2  IDLE=0, WARMUP=1, RUN=2, DRAIN=3.

Function
REQ-015 Divider counter dcnt SHALL count 0..DIV-1 and wrap to 0, advancing only in WARMUP and RUN; dcnt SHALL be forced to 0 in IDLE and DRAIN.
REQ-016 ad_clk SHALL be registered high when dcnt < DIV/2, else low, in WARMUP/RUN; ad_clk SHALL be low in IDLE and DRAIN.
REQ-017 A sample strobe SHALL occur in cycles where dcnt == DIV-1 in WARMUP/RUN; ad_in SHALL be captured on that edge.
REQ-018 Captured samples SHALL be converted to two's complement by inverting bit 11 (0x000 -> -2048, 0x800 -> 0, 0xFFF -> +2047).
REQ-019 IDLE -> WARMUP SHALL occur on the first clk edge with en=1; that transition SHALL clear ovf_cnt and the warm-up counter.
REQ-020 WARMUP SHALL count strobes and discard them; on the WARMUP-th strobe the state SHALL become RUN, and that strobe's sample SHALL also be discarded.
REQ-021 WARMUP with en=0 SHALL go directly to IDLE.
REQ-022 In RUN each strobe SHALL push the converted sample into the FIFO.
REQ-023 RUN with en=0 SHALL go to DRAIN; a strobe in that same cycle SHALL still be pushed.
REQ-024 DRAIN SHALL push nothing and SHALL go to IDLE in the cycle after the FIFO becomes empty; en is ignored in DRAIN.
REQ-025 s_valid SHALL equal FIFO non-empty; s_data SHALL be the oldest entry; a pop SHALL occur on any edge with s_valid && s_ready.
REQ-026 Latency: a sample pushed into an empty FIFO at edge T SHALL appear with s_valid=1 after edge T, i.e. in cycle T+1.
REQ-027 A push into a full FIFO without a simultaneous pop SHALL drop the new sample and increment ovf_cnt, which saturates at 255.
REQ-028 Simultaneous push and pop when full SHALL accept the push, with no overflow and occupancy unchanged.
REQ-029 s_data and FIFO order SHALL be preserved across pointer wrap-around.
REQ-030 s_data SHALL hold its value while s_valid=1 and s_ready=0.

Reset
REQ-031 rst_n low SHALL immediately set state=IDLE, ad_clk=0, s_valid=0, s_data=0, busy=0, ovf_cnt=0, FIFO empty, dcnt=0 and the warm-up counter to 0.
REQ-032 Reset mid-RUN or mid-DRAIN SHALL discard all FIFO contents; after release the block SHALL wait in IDLE for en.

Verification
REQ-033 Start/warm-up: DIV=4, WARMUP=8, en=1, ad_in ramp, s_ready=1 -> ad_clk 2 high/2 low; the first 8 strobes are discarded; the 9th strobe's sample (ad_in 0x805) appears as s_data=0x005 one cycle later.
REQ-034 Conversion: ad_in 0x000, 0x800, 0xFFF in RUN -> s_data 0x800, 0x000, 0x7FF.
REQ-035 Overflow: RUN, s_ready=0 for 10 strobes, DEPTH=4 -> 4 oldest samples held in order; ovf_cnt=6; 300 further blocked strobes -> ovf_cnt=255.
REQ-036 Full boundary: FIFO full with s_ready=1 exactly on a strobe cycle -> the new sample is accepted, ovf_cnt unchanged, order intact.
REQ-037 Stop/drain: en 1->0 with 3 entries queued, s_ready=1 -> ad_clk low, state=DRAIN, 3 pops, then IDLE with busy=0; en toggling during DRAIN has no effect.
REQ-038 Reset mid-RUN with 2 entries queued -> s_valid=0, state=0, ad_clk=0 immediately; no stale data after restart.
